alu_share_ctrl: RTL and testbench

- Two-requester round-robin controller that shares the single combinational ALU datapath (5-bit select, carry-in, 2-bit operands, 4-bit result).
- Accepts one operation per grant and drives the ALU from registered operands.
- Captures the ALU result and returns it to the owning requester over a valid/ready response channel.
- Sits between the two datapath clients and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC settles the ALU, RESP returns the result.
module alu_share_ctrl #(
  parameter int OPND_W = 2,
  parameter int RES_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [9:0]            req_sel,
  input  logic [1:0]            req_cin,
  input  logic [2*OPND_W-1:0]   req_a,
  input  logic [2*OPND_W-1:0]   req_b,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [RES_W-1:0]      rsp_y,
  output logic                  rsp_zero,
  output logic [4:0]            alu_select,
  output logic                  alu_c_in,
  output logic [OPND_W-1:0]     alu_a,
  output logic [OPND_W-1:0]     alu_b,
  input  logic [RES_W-1:0]      alu_y,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [4:0]          sel_q, sel_d;
  logic                cin_q, cin_d;
  logic [OPND_W-1:0]   a_q, a_d;
  logic [OPND_W-1:0]   b_q, b_d;
  logic [RES_W-1:0]    y_q, y_d;
  logic                zero_q, zero_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          grant_s;
  logic                win_s;

  // State register and latched operation/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      sel_q   <= 5'b00000;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, next-state and register updates.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    grant_s = 2'b00;
    win_s   = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not complete last wins.
        case (req_valid)
          2'b01: begin
            win_s   = 1'b0;
            grant_s = 2'b01;
          end
          2'b10: begin
            win_s   = 1'b1;
            grant_s = 2'b10;
          end
          2'b11: begin
            win_s   = ~last_q;
            grant_s = last_q ? 2'b01 : 2'b10;
          end
          default: begin
            win_s   = 1'b0;
            grant_s = 2'b00;
          end
        endcase
        if (grant_s != 2'b00) begin
          sel_d   = win_s ? req_sel[9:5] : req_sel[4:0];
          cin_d   = win_s ? req_cin[1] : req_cin[0];
          a_d     = win_s ? req_a[2*OPND_W-1:OPND_W] : req_a[OPND_W-1:0];
          b_d     = win_s ? req_b[2*OPND_W-1:OPND_W] : req_b[OPND_W-1:0];
          owner_d = win_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        y_d     = alu_y;
        zero_d  = (alu_y == '0);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The accept pulse is combinational with IDLE so it lands in the same cycle as the latch edge.
  assign req_ready  = grant_s & {2{rst_n}};
  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_y      = y_q;
  assign rsp_zero   = zero_q & (state_q == RESP);
  assign alu_select = sel_q;
  assign alu_c_in   = cin_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q == EXEC) || (state_q == RESP);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: a driver issues queued operations, a monitor checks
// arbitration, latency and results against a transaction-level model, with an ALU model attached.
module tb_alu_share_ctrl;

  localparam int OPND_W = 2;
  localparam int RES_W  = 4;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic [4:0] sel;
    logic       cin;
    logic [1:0] a;
    logic [1:0] b;
  } op_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
  logic [9:0]         req_sel;
  logic [3:0]         req_a, req_b;
  logic [RES_W-1:0]   rsp_y, alu_y;
  logic               rsp_zero, alu_c_in, busy;
  logic [4:0]         alu_select;
  logic [OPND_W-1:0]  alu_a, alu_b;
  logic [CNT_W-1:0]   op_count;

  op_t               todo_q [2][$];
  logic [RES_W-1:0]  exp_q  [2][$];
  int                checks = 0;
  int                failures = 0;
  int                tmo_cnt = 0;
  logic              rmode = 1'b0;
  logic [1:0]        rsp_fix = 2'b00;

  always #5 clk = ~clk;

  // Reference ALU: add with carry, two AND codes, and a mixing default for other codes.
  function automatic logic [3:0] alu_fn(op_t o);
    case (o.sel)
      5'b00001: return {2'b00, o.a} + {2'b00, o.b} + {3'b000, o.cin};
      5'b00100: return {2'b00, o.a & o.b};
      5'b11000: return {2'b00, o.a & o.b};
      default:  return ({o.a, o.b} ^ o.sel[3:0]) + {3'b000, o.cin};
    endcase
  endfunction

  assign alu_y = alu_fn({alu_select, alu_c_in, alu_a, alu_b});

  alu_share_ctrl #(.OPND_W(OPND_W), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_zero(rsp_zero),
    .alu_select(alu_select), .alu_c_in(alu_c_in), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: holds each request until accepted, then presents the next queued one.
  initial begin : driver
    op_t        cur [2];
    logic       act [2];
    logic [1:0] acc;
    for (int i = 0; i < 2; i++) begin
      cur[i] = '0;
      act[i] = 1'b0;
    end
    req_valid = 2'b00; req_sel = 10'd0; req_cin = 2'b00; req_a = 4'd0; req_b = 4'd0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          act[i] = 1'b0;
        end else begin
          if (act[i] && acc[i]) act[i] = 1'b0;
          if (!act[i] && todo_q[i].size() > 0) begin
            cur[i] = todo_q[i].pop_front();
            exp_q[i].push_back(alu_fn(cur[i]));
            act[i] = 1'b1;
          end
        end
      end
      req_valid = {act[1], act[0]};
      req_sel   = {cur[1].sel, cur[0].sel};
      req_cin   = {cur[1].cin, cur[0].cin};
      req_a     = {cur[1].a, cur[0].a};
      req_b     = {cur[1].b, cur[0].b};
    end
  end

  // Response-ready driver: fixed value from the sequencer or random per cycle.
  initial begin : rsp_drv
    rsp_ready = 2'b00;
    forever begin
      @(posedge clk);
      #3;
      rsp_ready = rmode ? 2'($urandom_range(0, 3)) : rsp_fix;
    end
  end

  // Monitor: transaction-level model of arbitration, timing and results.
  initial begin : monitor
    logic             m_inflight, m_owner, m_last;
    int               m_ph, tmo_seen;
    logic [CNT_W-1:0] m_cnt;
    op_t              m_op;
    logic [1:0]       exp_rdy, exp_rv;
    logic [RES_W-1:0] e;
    m_inflight = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_ph = 0; m_cnt = '0; m_op = '0;
    tmo_seen = 0;
    forever begin
      @(negedge clk);
      if (tmo_cnt != tmo_seen) begin
        chk("wait_timeout", tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (!rst_n) begin
        chk("reset_outputs", {req_ready, rsp_valid, rsp_y, rsp_zero, alu_select, alu_c_in,
                              alu_a, alu_b, busy, op_count}, 32'd0);
        m_inflight = 1'b0; m_last = 1'b1; m_cnt = '0; m_ph = 0;
      end else begin
        exp_rdy = 2'b00;
        if (!m_inflight) begin
          case (req_valid)
            2'b01:   exp_rdy = 2'b01;
            2'b10:   exp_rdy = 2'b10;
            2'b11:   exp_rdy = m_last ? 2'b01 : 2'b10;
            default: exp_rdy = 2'b00;
          endcase
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, m_inflight);
        chk("op_count", op_count, m_cnt);
        exp_rv = (m_inflight && m_ph >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("rsp_valid", rsp_valid, exp_rv);
        if (m_inflight && m_ph == 1)
          chk("alu_inputs", {alu_select, alu_c_in, alu_a, alu_b}, m_op);
        if (exp_rv != 2'b00) begin
          if (exp_q[m_owner].size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q[m_owner][0];
            chk("rsp_y", rsp_y, e);
            chk("rsp_zero", rsp_zero, e == 4'd0);
            if (rsp_ready[m_owner]) begin
              void'(exp_q[m_owner].pop_front());
              m_inflight = 1'b0;
              m_last = m_owner;
              m_cnt = m_cnt + CNT_W'(1);
            end
          end
        end else begin
          chk("rsp_zero_idle", rsp_zero, 32'd0);
        end
        if (m_inflight) m_ph++;
        if (exp_rdy != 2'b00) begin
          m_inflight = 1'b1;
          m_ph = 1;
          m_owner = exp_rdy[1];
          m_op = m_owner ? {req_sel[9:5], req_cin[1], req_a[3:2], req_b[3:2]}
                         : {req_sel[4:0], req_cin[0], req_a[1:0], req_b[1:0]};
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (todo_q[0].size() == 0 && todo_q[1].size() == 0 && exp_q[0].size() == 0 &&
          exp_q[1].size() == 0 && !busy && req_valid == 2'b00) return;
    end
    tmo_cnt++;
  endtask

  task automatic wait_sig(input logic [1:0] rv, input logic [1:0] rr, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rsp_valid == rv && req_ready == rr) return;
    end
    tmo_cnt++;
  endtask

  task automatic flush();
    for (int i = 0; i < 2; i++) begin
      todo_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  // Sequencer: directed scenarios followed by a randomized burst.
  initial begin : seq
    op_t        r;
    logic [31:0] w;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    todo_q[0].push_back('{sel: 5'b00001, cin: 1'b0, a: 2'd2, b: 2'd3});
    rsp_fix = 2'b01;
    wait_done(40);

    rsp_fix = 2'b11;
    for (int i = 0; i < 4; i++) begin
      todo_q[0].push_back('{sel: 5'b00001, cin: 1'b1, a: 2'd3, b: 2'd3});
      todo_q[1].push_back('{sel: 5'b00100, cin: 1'b0, a: 2'd3, b: 2'd1});
    end
    wait_done(100);

    rsp_fix = 2'b00;
    todo_q[1].push_back('{sel: 5'b11000, cin: 1'b0, a: 2'd2, b: 2'd1});
    wait_sig(2'b10, 2'b00, 20);
    todo_q[0].push_back('{sel: 5'b00001, cin: 1'b1, a: 2'd1, b: 2'd2});
    repeat (5) @(posedge clk);
    #2 rsp_fix = 2'b11;
    wait_done(40);

    todo_q[0].push_back('{sel: 5'b00100, cin: 1'b1, a: 2'd3, b: 2'd2});
    rsp_fix = 2'b10;
    wait_sig(2'b01, 2'b00, 20);
    repeat (4) @(posedge clk);
    #2 rsp_fix = 2'b01;
    wait_done(40);

    rsp_fix = 2'b11;
    todo_q[1].push_back('{sel: 5'b00001, cin: 1'b0, a: 2'd1, b: 2'd1});
    wait_sig(2'b00, 2'b10, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    todo_q[0].push_back('{sel: 5'b00001, cin: 1'b0, a: 2'd3, b: 2'd2});
    todo_q[1].push_back('{sel: 5'b00100, cin: 1'b0, a: 2'd2, b: 2'd3});
    #2 rst_n = 1'b1;
    wait_done(60);

    rmode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      r = w[9:0];
      todo_q[w[10]].push_back(r);
    end
    wait_done(3000);
    rmode = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
